// File: rtl/md_pkg.sv
// Shared types and defaults for the multiply/divide unit controller.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam int MD_MULT_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF  = 10;

  // True for the ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_md_arith(md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_mult(md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational HI/LO result for mult/multu/div/divu.
// res_wr=0 means HI/LO must be left untouched (divide by zero, non-arith op).
module md_alu
  import md_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_wr
);

  logic        sgn_mul;
  logic        sgn_div;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvsr;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;

  assign sgn_mul = (op == MD_MULT);
  assign sgn_div = (op == MD_DIV);

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned product
  // equal to the signed product, so one multiplier serves both forms.
  assign prod = {{32{sgn_mul & a[31]}}, a} * {{32{sgn_mul & b[31]}}, b};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign a_neg = sgn_div & a[31];
  assign b_neg = sgn_div & b[31];
  assign mag_a = a_neg ? (~a + 32'd1) : a;
  assign mag_b = b_neg ? (~b + 32'd1) : b;
  assign dvsr  = (b == 32'd0) ? 32'd1 : mag_b;
  assign uq    = mag_a / dvsr;
  assign ur    = mag_a % dvsr;
  assign quo   = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
  assign rem   = a_neg ? (~ur + 32'd1) : ur;

  // Select the result pair for the requested op.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        res_wr = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        if (b != 32'd0) begin
          res_hi = rem;
          res_lo = quo;
          res_wr = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, holds the unit busy for a fixed
// latency per op, and raises the D-stage stall for MD-class instructions.
//
// state   | meaning
// MD_IDLE | unit free; arith op starts, mthi/mtlo write directly
// MD_BUSY | latency countdown; pending result commits when count hits 1
module md_unit_ctrl
  import md_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT_DEF,
  parameter int DIV_LAT  = MD_DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  e_op,
  input  logic        e_valid,
  input  logic [31:0] e_a,
  input  logic [31:0] e_b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] e_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   state;
  md_state_t   state_nxt;
  md_op_t      op;
  logic        start;
  logic        last_cnt;
  logic [CNT_W-1:0] cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;
  logic [31:0] alu_hi;
  logic [31:0] alu_lo;
  logic        alu_wr;

  assign op       = md_op_t'(e_op);
  assign start    = e_valid & is_md_arith(op) & (state == MD_IDLE);
  assign last_cnt = (cnt == CNT_W'(1));

  md_alu u_alu (
    .op     (op),
    .a      (e_a),
    .b      (e_b),
    .res_hi (alu_hi),
    .res_lo (alu_lo),
    .res_wr (alu_wr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= MD_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: leave BUSY on the edge where the countdown expires.
  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start)    state_nxt = MD_BUSY;
      MD_BUSY: if (last_cnt) state_nxt = MD_IDLE;
      default:               state_nxt = MD_IDLE;
    endcase
  end

  // Outputs: busy flag, hazard stall and mfhi/mflo read path.
  always_comb begin
    busy     = (state == MD_BUSY);
    md_stall = d_is_md & (busy | start);
    e_rdata  = 32'd0;
    if (e_valid && op == MD_MFHI) e_rdata = hi;
    if (e_valid && op == MD_MFLO) e_rdata = lo;
  end

  // Countdown, pending result capture, and HI/LO updates.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      if (start) begin
        cnt     <= is_md_mult(op) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
        pend_hi <= alu_hi;
        pend_lo <= alu_lo;
        pend_wr <= alu_wr;
      end else if (state == MD_BUSY) begin
        cnt <= cnt - CNT_W'(1);
        if (last_cnt && pend_wr) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
      if (state == MD_IDLE && e_valid && op == MD_MTHI) hi <= e_a;
      if (state == MD_IDLE && e_valid && op == MD_MTLO) lo <= e_a;
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: timestamp-based reference model plus literal pins.
module tb_md_unit_ctrl;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  e_op = 4'd0;
  logic        e_valid = 1'b0;
  logic [31:0] e_a = 32'd0;
  logic [31:0] e_b = 32'd0;
  logic        d_is_md = 1'b0;
  logic        busy;
  logic        md_stall;
  logic [31:0] e_rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  bit cmp_en = 1'b0;

  md_unit_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .e_op     (e_op),
    .e_valid  (e_valid),
    .e_a      (e_a),
    .e_b      (e_b),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .md_stall (md_stall),
    .e_rdata  (e_rdata),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle k is busy iff start_cycle < k <= start_cycle + lat.
  int          cyc = 0;
  bit          m_act = 1'b0;
  int          m_start = 0;
  int          m_lat = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  bit          m_pwr = 1'b0;

  function automatic bit m_busy_now();
    return m_act && (cyc > m_start) && (cyc <= m_start + m_lat);
  endfunction

  function automatic bit arith(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  always @(posedge clk) begin
    bit          bz;
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    if (!reset_n) begin
      m_hi = 32'd0;
      m_lo = 32'd0;
      m_act = 1'b0;
    end else begin
      bz = m_busy_now();
      if (e_valid && e_op != 4'd0 && e_op <= 4'd8 && bz) viol++;
      if (bz && cyc == m_start + m_lat) begin
        if (m_pwr) begin
          m_hi = m_phi;
          m_lo = m_plo;
        end
        m_act = 1'b0;
      end
      if (!bz && e_valid) begin
        if (arith(e_op)) begin
          m_act = 1'b1;
          m_start = cyc;
          m_lat = (e_op <= 4'd2) ? 5 : 10;
          m_pwr = 1'b1;
          sa = e_a;
          sb = e_b;
          case (e_op)
            4'd1: begin
              sp = longint'(sa) * longint'(sb);
              {m_phi, m_plo} = sp;
            end
            4'd2: begin
              up = {32'd0, e_a} * {32'd0, e_b};
              {m_phi, m_plo} = up;
            end
            4'd3: begin
              if (e_b == 32'd0) m_pwr = 1'b0;
              else if (e_a == 32'h8000_0000 && e_b == 32'hFFFF_FFFF) begin
                m_plo = 32'h8000_0000;
                m_phi = 32'd0;
              end else begin
                m_plo = sa / sb;
                m_phi = sa % sb;
              end
            end
            default: begin
              if (e_b == 32'd0) m_pwr = 1'b0;
              else begin
                m_plo = e_a / e_b;
                m_phi = e_a % e_b;
              end
            end
          endcase
        end else if (e_op == 4'd5) m_hi = e_a;
        else if (e_op == 4'd6) m_lo = e_a;
      end
    end
    cyc++;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit          eb, es;
    logic [31:0] er;
    if (cmp_en) begin
      eb = m_busy_now();
      es = e_valid && arith(e_op) && !eb;
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("md_stall", {31'd0, md_stall}, {31'd0, d_is_md && (eb || es)});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      if (e_valid) begin
        er = (e_op == 4'd7) ? m_hi : (e_op == 4'd8) ? m_lo : 32'd0;
        chk("e_rdata", e_rdata, er);
      end
    end
  end

  task automatic step(input bit rn, input bit v, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input bit dmd);
    @(posedge clk);
    #1;
    reset_n = rn;
    e_valid = v;
    e_op    = op;
    e_a     = a;
    e_b     = b;
    d_is_md = dmd;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit dmd);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, MD_NONE, 32'd0, 32'd0, dmd);
  endtask

  initial begin
    int nb;
    step(1'b0, 1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
    cmp_en = 1'b1;
    step(1'b0, 1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
    step(1'b0, 1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // mult -1 * 3 with d_is_md held: stall in start cycle and 5 busy cycles
    step(1'b1, 1'b1, MD_MULT, 32'hFFFF_FFFF, 32'd3, 1'b1);
    chk("mult_stall_start", {31'd0, md_stall}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      idle(1, 1'b1);
      chk("mult_busy_win", {31'd0, busy}, 32'd1);
      chk("mult_stall_win", {31'd0, md_stall}, 32'd1);
    end
    idle(1, 1'b1);
    chk("mult_busy_end", {31'd0, busy}, 32'd0);
    chk("mult_stall_end", {31'd0, md_stall}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFD);

    // multu same operands, no D-stage MD op
    step(1'b1, 1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd3, 1'b0);
    idle(6, 1'b0);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFD);

    // div -7 / 2
    step(1'b1, 1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(10, 1'b0);
    chk("div_hi_before", hi, 32'h0000_0002);
    idle(1, 1'b0);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);

    // divu 7 / 0: full latency, HI/LO unchanged
    step(1'b1, 1'b1, MD_DIVU, 32'd7, 32'd0, 1'b0);
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1, 1'b0);
      if (busy) nb++;
    end
    chk("div0_busy_cycles", nb, 32'd10);
    chk("div0_hi", hi, 32'hFFFF_FFFF);
    chk("div0_lo", lo, 32'hFFFF_FFFD);

    // overflow 0x80000000 / -1
    step(1'b1, 1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(11, 1'b0);
    chk("ovf_hi", hi, 32'h0000_0000);
    chk("ovf_lo", lo, 32'h8000_0000);

    // mthi/mfhi and mtlo/mflo
    step(1'b1, 1'b1, MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    step(1'b1, 1'b1, MD_MFHI, 32'd0, 32'd0, 1'b0);
    chk("mfhi_rdata", e_rdata, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    step(1'b1, 1'b1, MD_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
    step(1'b1, 1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0);
    chk("mflo_rdata", e_rdata, 32'hCAFE_F00D);

    // e_valid=0: a mult opcode on a bubble does nothing
    step(1'b1, 1'b0, MD_MULT, 32'd9, 32'd9, 1'b1);
    chk("bubble_stall", {31'd0, md_stall}, 32'd0);
    idle(1, 1'b0);
    chk("bubble_busy", {31'd0, busy}, 32'd0);

    // mult 2*3, mtlo while busy is ignored and flagged
    chk("viol_none", viol, 32'd0);
    step(1'b1, 1'b1, MD_MULT, 32'd2, 32'd3, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 1'b1, MD_MTLO, 32'h0000_DEAD, 32'd0, 1'b0);
    idle(4, 1'b0);
    chk("viol_lo", lo, 32'd6);
    chk("viol_hi", hi, 32'd0);
    chk("viol_count", viol, 32'd1);

    // back-to-back mults at T and T+6
    step(1'b1, 1'b1, MD_MULT, 32'd5, 32'd7, 1'b0);
    idle(5, 1'b0);
    step(1'b1, 1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd4, 1'b0);
    chk("b2b_lo1", lo, 32'd35);
    chk("b2b_stall_free", {31'd0, busy}, 32'd0);
    idle(5, 1'b0);
    idle(1, 1'b0);
    chk("b2b_hi2", hi, 32'hFFFF_FFFF);
    chk("b2b_lo2", lo, 32'hFFFF_FFF8);

    // reset in busy cycle 3 of a div
    step(1'b1, 1'b1, MD_DIV, 32'd100, 32'd7, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
    idle(1, 1'b0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    idle(10, 1'b0);
    chk("rstmid_nocommit_lo", lo, 32'd0);

    // recovery after reset
    step(1'b1, 1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0);
    idle(11, 1'b0);
    chk("recover_hi", hi, 32'd2);
    chk("recover_lo", lo, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
